// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the iterative multiplier/divider sharing one HI/LO pair.
// Accepts one MULT/DIV request at a time, pulses the selected unit's start,
// waits for its done, then pulses the HI/LO write enables.
// Divide-by-zero is flagged without ever starting the divider.
// Optional feature macro: MULDIV_TIMEOUT_EN (aborts a WAIT that reaches TIMEOUT cycles).
module muldiv_sequencer #(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_is_div,
    input  logic             divisor_zero,
    output logic             req_ready,
    output logic             mult_start,
    output logic             div_start,
    input  logic             mult_done,
    input  logic             div_done,
    output logic             hi_write,
    output logic             lo_write,
    input  logic             hilo_rd_req,
    output logic             busy,
    output logic             stall,
    output logic             div0_exc,
    output logic             timeout_err,
    output logic [CNT_W-1:0] last_latency
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef MULDIV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
`ifdef MULDIV_TIMEOUT_EN
        S_EXC   = 3'd4,
        S_ABORT = 3'd5
`else
        S_EXC   = 3'd4
`endif
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] lat_d;
    logic             op_is_div;
    logic             op_d;
    logic             sel_done;

    // State, wait counter, latched op type and last latency registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_latency <= '0;
            op_is_div    <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            last_latency <= lat_d;
            op_is_div    <= op_d;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_d       = last_latency;
        op_d        = op_is_div;
        req_ready   = 1'b0;
        busy        = 1'b1;
        mult_start  = 1'b0;
        div_start   = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
        div0_exc    = 1'b0;
        timeout_err = 1'b0;

        // Saturating count of the WAIT cycle now in progress (k = cnt + 1)
        cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        // Only the unit that was started is allowed to complete the operation
        sel_done = op_is_div ? div_done : mult_done;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (req_is_div && divisor_zero) begin
                        state_d = S_EXC;
                    end else begin
                        op_d    = req_is_div;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                mult_start = !op_is_div;
                div_start  = op_is_div;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (sel_done) begin
                    lat_d   = cnt_inc;
                    state_d = S_WRITE;
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d = S_ABORT;
                end
`endif
            end
            S_WRITE: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
                state_d  = S_IDLE;
            end
            S_EXC: begin
                div0_exc = 1'b1;
                state_d  = S_IDLE;
            end
`ifdef MULDIV_TIMEOUT_EN
            S_ABORT: begin
                timeout_err = 1'b1;
                state_d     = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Hold the main FSM while a new request or HI/LO read collides with an op in flight
    assign stall = busy && (req_valid || hilo_rd_req);

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controller that sequences the iterative multiplier and divider for the multi-cycle CPU. It shares the single HI/LO register pair between the two units.
- Sits between the main control FSM and the mult/div units. It accepts one MULT/DIV request at a time, issues a one-cycle start pulse to the selected unit, and waits for that unit's done.
- On done it pulses HI/LO write enables. It generates a pipeline stall for new requests or MFHI/MFLO reads while the operation is in flight.
- It flags divide-by-zero without ever starting the divider.

Parameters:
- CNT_W, 6, width of the wait-cycle counter and of last_latency.
- TIMEOUT, 40, maximum WAIT cycles before abort. Used only with MULDIV_TIMEOUT_EN; must be in 1..2^CNT_W-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all registers.
- req_valid  input  1  MULT/DIV request from the control FSM.
- req_is_div  input  1  1 = DIV, 0 = MULT; sampled on accept.
- divisor_zero  input  1  divisor operand == 0; sampled on accept, used only when req_is_div=1.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- div_start  output  1  one-cycle start pulse to the divider.
- mult_done  input  1  multiplier result valid (level or pulse).
- div_done  input  1  divider result valid (level or pulse).
- hi_write  output  1  HI register write enable.
- lo_write  output  1  LO register write enable.
- hilo_rd_req  input  1  MFHI/MFLO is in its read cycle.
- busy  output  1  high in any state other than IDLE.
- stall  output  1  hold the main FSM.
- div0_exc  output  1  one-cycle divide-by-zero flag.
- timeout_err  output  1  one-cycle timeout abort flag; constant 0 without MULDIV_TIMEOUT_EN.
- last_latency  output  CNT_W  number of WAIT cycles of the last successfully completed operation.

Behaviour:
- Reset values:
  - state = IDLE, counter = 0, last_latency = 0, op_is_div = 0.
  - Every output is 0 except req_ready = 1.
  - Reset asserted mid-operation aborts immediately. No hi_write/lo_write is issued and no exception is flagged.
- States and transitions:
  - IDLE: req_ready = 1. On accept:
    - req_is_div && divisor_zero -> EXC.
    - Otherwise latch op_is_div = req_is_div -> START.
  - START: exactly one cycle. mult_start = !op_is_div, div_start = op_is_div. Set counter = 0. -> WAIT.
  - WAIT:
    - counter increments every cycle, saturating at 2^CNT_W-1.
    - Only the selected unit's done is sampled; the other unit's done is ignored.
    - Done high in the k-th WAIT cycle (k = 1 on the first) -> last_latency = k (saturated), then -> WRITE.
    - Done during START is ignored.
  - WRITE: exactly one cycle, hi_write = lo_write = 1, -> IDLE. HI/LO hold the new values from the following cycle.
  - EXC: exactly one cycle, div0_exc = 1, no start pulse, no HI/LO write, -> IDLE. last_latency is unchanged.
- Output timing:
  - All outputs except stall are decoded from registered state only (Moore).
  - Start, write and exception pulses each last exactly one cycle.
- Stall: stall = busy && (req_valid || hilo_rd_req). This is combinational.
  - A read during WRITE stalls; the read proceeds in the following IDLE cycle.
  - A request arriving in the same cycle the block returns to IDLE is accepted in that cycle.
- Back-to-back operations: minimum issue interval is 4 cycles (IDLE, START, WAIT ≥1, WRITE).
- req_is_div and divisor_zero are don't-care when no accept occurs.

Optional Feature:
- Macro: MULDIV_TIMEOUT_EN.
- Enabled: in WAIT, if counter reaches TIMEOUT with no done, the block enters a one-cycle ABORT state.
  - ABORT drives timeout_err = 1, issues no HI/LO write, leaves last_latency unchanged, then -> IDLE.
  - Done sampled in the same cycle the counter reaches TIMEOUT wins, i.e. normal completion.
- Disabled: the block waits in WAIT indefinitely and timeout_err is tied to 0. The ABORT state does not exist.

Test Plan:
- Reset, then MULT accept at cycle 0, mult_done raised in the 3rd WAIT cycle -> mult_start high only at cycle 1, hi_write = lo_write = 1 at cycle 5, last_latency = 3, req_ready back to 1 at cycle 6.
- DIV with divisor_zero = 1 -> div0_exc for exactly 1 cycle in the next cycle, div_start/hi_write/lo_write never asserted, last_latency unchanged.
- DIV in progress with spurious mult_done pulses during WAIT -> pulses ignored; completion only on div_done; exactly one write pulse.
- hilo_rd_req held high from START through WRITE -> stall = 1 in every one of those cycles, stall = 0 in the first IDLE cycle; a new req_valid held during WAIT stalls and is accepted in that IDLE cycle.
- Reset asserted in the 2nd WAIT cycle, then mult_done high -> immediate IDLE, no hi_write/lo_write, busy = 0, last_latency = 0.
- With MULDIV_TIMEOUT_EN and TIMEOUT = 5, no done -> timeout_err for 1 cycle after the 5th WAIT cycle, no write; repeat with done in the 5th WAIT cycle -> normal WRITE, last_latency = 5.
